// File: rtl/prm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prm_pkg
// Purpose  : Shared widths, cube record and FSM encoding for the edge mask engine.
// Revision : 1.0 - initial release
// ============================================================================
package prm_pkg;

  localparam int CODE_W   = 15;
  localparam int N_EDGE   = 8;
  localparam int N_TERM   = 128;
  localparam int TERM_PAR = 4;

  localparam int EDGE_W = $clog2(N_EDGE);
  localparam int IDX_W  = $clog2(N_TERM);
  localparam int CNT_W  = $clog2(N_TERM + 1);

  typedef struct packed {
    logic [CODE_W-1:0] care;
    logic [CODE_W-1:0] val;
  } cube_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    MERGE = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Clamp a requested cube count to the table depth.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(N_TERM)) ? CNT_W'(N_TERM) : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prm_edge_mask_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : prm_edge_mask_engine_if
// Purpose  : Config, code-stream and mask handshake bundle for the engine.
// Revision : 1.0 - initial release
// ============================================================================
interface prm_edge_mask_engine_if;
  import prm_pkg::*;

  logic                cfg_we;
  logic                cfg_ready;
  logic [EDGE_W-1:0]   cfg_edge;
  logic [IDX_W-1:0]    cfg_idx;
  logic [CODE_W-1:0]   cfg_care;
  logic [CODE_W-1:0]   cfg_val;
  logic                cfg_cnt_we;
  logic [CNT_W-1:0]    cfg_cnt;
  logic                in_valid;
  logic                in_ready;
  logic [CODE_W-1:0]   in_code;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [N_EDGE-1:0]   edge_mask;
  logic                busy;

  modport master (
    output cfg_we, cfg_edge, cfg_idx, cfg_care, cfg_val, cfg_cnt_we, cfg_cnt,
    output in_valid, in_code, in_last, out_ready,
    input  cfg_ready, in_ready, out_valid, edge_mask, busy
  );

  modport slave (
    input  cfg_we, cfg_edge, cfg_idx, cfg_care, cfg_val, cfg_cnt_we, cfg_cnt,
    input  in_valid, in_code, in_last, out_ready,
    output cfg_ready, in_ready, out_valid, edge_mask, busy
  );

endinterface
`default_nettype wire

// File: rtl/prm_cube_bank.sv
`default_nettype none
// ============================================================================
// Module   : prm_cube_bank
// Purpose  : Cube storage for one edge plus a TERM_PAR-wide match/OR slice.
// Revision : 1.0 - initial release
// ============================================================================
module prm_cube_bank
  import prm_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              wr_en,
  input  wire logic [IDX_W-1:0]  wr_idx,
  input  wire cube_t             wr_cube,
  input  wire logic [CODE_W-1:0] code,
  input  wire logic [CNT_W-1:0]  base,
  input  wire logic [CNT_W-1:0]  cnt,
  output logic                   hit
);

  // Storage is deliberately unreset; a zero count keeps stale entries inert.
  cube_t mem [N_TERM];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_cube;
  end

  logic [TERM_PAR-1:0] w_match;

  generate
    for (genvar p = 0; p < TERM_PAR; p++) begin : g_slice
      logic [CNT_W-1:0] term_idx;
      cube_t            slot;
      assign term_idx   = base + CNT_W'(p);
      assign slot       = mem[term_idx[IDX_W-1:0]];
      assign w_match[p] = (term_idx < cnt) && (((code ^ slot.val) & slot.care) == '0);
    end
  endgenerate

  assign hit = |w_match;

endmodule
`default_nettype wire

// File: rtl/prm_edge_mask_engine.sv
`default_nettype none
// ============================================================================
// Module   : prm_edge_mask_engine
// Purpose  : Programmable cube-list obstacle checker producing one blocked-edge
//            mask per code batch. Optional macro PRM_EARLY_EXIT_EN ends EVAL
//            once every edge is already blocked.
// Revision : 1.0 - initial release
// ============================================================================
module prm_edge_mask_engine
  import prm_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst_n,
  prm_edge_mask_engine_if.slave bus
);

  state_t              state;
  logic [CODE_W-1:0]   code_r;
  logic                last_r;
  logic [N_EDGE-1:0]   hit_r;
  logic [N_EDGE-1:0]   acc_r;
  logic                acc_busy;
  logic [CNT_W-1:0]    idx_r;
  logic [CNT_W-1:0]    cnt [N_EDGE];
  logic                out_valid_r;
  logic [N_EDGE-1:0]   edge_mask_r;

  logic [N_EDGE-1:0]   w_bank_hit;
  logic [N_EDGE-1:0]   w_hit_next;
  logic [CNT_W-1:0]    w_max_cnt;
  logic [CNT_W:0]      w_idx_next;
  logic                w_eval_done;
  logic                w_stop;
  logic                w_cfg_fire;
  logic                w_cnt_fire;
  cube_t               w_wr_cube;

  assign bus.cfg_ready = (state == IDLE) && !acc_busy;
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE) || acc_busy;
  assign bus.out_valid = out_valid_r;
  assign bus.edge_mask = edge_mask_r;

  assign w_cfg_fire = bus.cfg_we     && bus.cfg_ready;
  assign w_cnt_fire = bus.cfg_cnt_we && bus.cfg_ready;
  assign w_wr_cube  = '{care: bus.cfg_care, val: bus.cfg_val};

  generate
    for (genvar e = 0; e < N_EDGE; e++) begin : g_bank
      prm_cube_bank u_bank (
        .clk     (clk),
        .wr_en   (w_cfg_fire && (bus.cfg_edge == EDGE_W'(e))),
        .wr_idx  (bus.cfg_idx),
        .wr_cube (w_wr_cube),
        .code    (code_r),
        .base    (idx_r),
        .cnt     (cnt[e]),
        .hit     (w_bank_hit[e])
      );
    end
  endgenerate

  // Pass length is set by the longest list so all edges finish together.
  always_comb begin
    w_max_cnt = '0;
    for (int e = 0; e < N_EDGE; e++) begin
      if (cnt[e] > w_max_cnt) w_max_cnt = cnt[e];
    end
  end

  assign w_hit_next  = hit_r | w_bank_hit;
  assign w_idx_next  = {1'b0, idx_r} + (CNT_W+1)'(TERM_PAR);
  assign w_eval_done = (w_idx_next >= {1'b0, w_max_cnt});

`ifdef PRM_EARLY_EXIT_EN
  assign w_stop = w_eval_done || (&(acc_r | w_hit_next));
`else
  assign w_stop = w_eval_done;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      code_r      <= '0;
      last_r      <= 1'b0;
      hit_r       <= '0;
      acc_r       <= '0;
      acc_busy    <= 1'b0;
      idx_r       <= '0;
      out_valid_r <= 1'b0;
      edge_mask_r <= '0;
      for (int e = 0; e < N_EDGE; e++) cnt[e] <= '0;
    end else begin
      if (w_cnt_fire) cnt[bus.cfg_edge] <= sat_cnt(bus.cfg_cnt);

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            code_r   <= bus.in_code;
            last_r   <= bus.in_last;
            hit_r    <= '0;
            idx_r    <= '0;
            acc_busy <= 1'b1;
            state    <= EVAL;
          end
        end
        EVAL: begin
          hit_r <= w_hit_next;
          idx_r <= w_idx_next[CNT_W-1:0];
          if (w_stop) state <= MERGE;
        end
        MERGE: begin
          acc_r <= acc_r | hit_r;
          if (last_r) begin
            edge_mask_r <= acc_r | hit_r;
            out_valid_r <= 1'b1;
            state       <= OUT;
          end else begin
            state <= IDLE;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            acc_r       <= '0;
            acc_busy    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prm_edge_mask_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_prm_edge_mask_engine
// Purpose  : Directed self-checking bench for prm_edge_mask_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prm_edge_mask_engine;
  import prm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   lat;

  always #5 clk = ~clk;

  prm_edge_mask_engine_if bus ();

  prm_edge_mask_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_cube(input int e, input int i, input logic [CODE_W-1:0] care,
                          input logic [CODE_W-1:0] val);
    bus.cfg_we   = 1'b1;
    bus.cfg_edge = EDGE_W'(e);
    bus.cfg_idx  = IDX_W'(i);
    bus.cfg_care = care;
    bus.cfg_val  = val;
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic cfg_count(input int e, input int c);
    bus.cfg_cnt_we = 1'b1;
    bus.cfg_edge   = EDGE_W'(e);
    bus.cfg_cnt    = CNT_W'(c);
    tick();
    bus.cfg_cnt_we = 1'b0;
  endtask

  // Latency = cycles from the accepting cycle to in_ready or out_valid returning.
  task automatic send(input logic [CODE_W-1:0] code, input logic last, output int n);
    int guard = 0;
    while (!bus.in_ready && guard < 1000) begin
      tick();
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!(bus.in_ready || bus.out_valid) && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic get_mask(input string tag, input logic [N_EDGE-1:0] exp);
    int guard = 0;
    while (!bus.out_valid && guard < 300) begin
      tick();
      guard++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_mask"}, 32'(bus.edge_mask), 32'(exp));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_edge = '0; bus.cfg_idx = '0; bus.cfg_care = '0;
    bus.cfg_val = '0; bus.cfg_cnt_we = 1'b0; bus.cfg_cnt = '0;
    bus.in_valid = 1'b0; bus.in_code = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_edge_mask", 32'(bus.edge_mask), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);

    // Single exact-match cube on edge 0.
    cfg_cube(0, 0, 15'h7FFF, 15'h1234);
    cfg_count(0, 1);
    send(15'h1234, 1'b1, lat);
    check("exact_lat", 32'(lat), 32'd3);
    get_mask("exact", 8'h01);

    // All counts zero: three codes, one EVAL cycle each.
    cfg_count(0, 0);
    send(15'h1234, 1'b0, lat);
    check("zero_lat0", 32'(lat), 32'd3);
    check("zero_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    check("zero_busy", 32'(bus.busy), 32'd1);
    send(15'h7FFF, 1'b0, lat);
    check("zero_lat1", 32'(lat), 32'd3);
    send(15'h0000, 1'b1, lat);
    check("zero_lat2", 32'(lat), 32'd3);
    get_mask("zero", 8'h00);

    // Edge 3: single-literal cube deep in a full table, fillers never match.
    for (int i = 0; i < N_TERM; i++) begin
      if (i == 77) cfg_cube(3, i, 15'h0001, 15'h0001);
      else         cfg_cube(3, i, 15'h7FFF, 15'h7FFF);
    end
    cfg_count(3, 128);
    send(15'h0002, 1'b0, lat);
    check("deep_lat0", 32'(lat), 32'd34);
    send(15'h0003, 1'b1, lat);
    check("deep_lat1", 32'(lat), 32'd34);
    get_mask("deep", 8'h08);

    cfg_count(3, 77);
    send(15'h0003, 1'b1, lat);
    check("cnt77_lat", 32'(lat), 32'd22);
    get_mask("cnt77", 8'h00);

    cfg_count(3, 78);
    send(15'h0003, 1'b1, lat);
    check("cnt78_lat", 32'(lat), 32'd22);
    get_mask("cnt78", 8'h08);

    cfg_count(3, 200);
    send(15'h0001, 1'b1, lat);
    check("sat_lat", 32'(lat), 32'd34);
    get_mask("sat", 8'h08);

    // Every edge blocked by a care=0 cube.
    for (int e = 0; e < N_EDGE; e++) begin
      cfg_cube(e, 0, 15'h0000, 15'h0000);
      cfg_count(e, 128);
    end
    send(15'h4321, 1'b1, lat);
`ifdef PRM_EARLY_EXIT_EN
    check("all_lat", 32'(lat), 32'd3);
`else
    check("all_lat", 32'(lat), 32'd34);
`endif
    get_mask("all", 8'hFF);

    // Writes attempted mid-batch must be dropped.
    for (int e = 0; e < N_EDGE; e++) cfg_count(e, 0);
    cfg_cube(1, 0, 15'h7FFF, 15'h0055);
    cfg_count(1, 1);
    send(15'h0011, 1'b0, lat);
    check("busy_lat0", 32'(lat), 32'd3);
    check("busy_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    cfg_cube(1, 0, 15'h0000, 15'h0000);
    cfg_count(2, 1);
    send(15'h0055, 1'b1, lat);
    check("busy_lat1", 32'(lat), 32'd3);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_mask", 32'(bus.edge_mask), 32'h02);
    end
    check("hold_valid", 32'(bus.out_valid), 32'd1);
    check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    get_mask("hold", 8'h02);
    send(15'h0011, 1'b1, lat);
    get_mask("old_table", 8'h00);

    // Asynchronous reset in the middle of EVAL.
    cfg_count(3, 128);
    bus.in_valid = 1'b1;
    bus.in_code  = 15'h0000;
    bus.in_last  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    check("arst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("arst_busy",      32'(bus.busy),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(15'h0000, 1'b1, lat);
    check("post_rst_lat", 32'(lat), 32'd3);
    get_mask("post_rst", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
